// File: rtl/xor_fold_pkg.sv
// Shared definitions for the xor_fold_pipe block: mode encodings and
// packet tracker states.
package xor_fold_pkg;

    localparam logic MODE_PASS  = 1'b0;
    localparam logic MODE_ACCUM = 1'b1;

    // PASS_PKT is transient: a PASS beat leaves IDLE and returns to IDLE in
    // the same cycle, so it never needs a stored encoding.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1
    } trk_state_e;

endpackage

// File: rtl/xor_fold_stage.sv
// One pipeline register slice carrying {valid, data, count, parity}.
// Holds when en is low; bubbles shift like data when en is high.
module xor_fold_stage
    import xor_fold_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic [CNT_W-1:0] in_count,
    input  logic             in_parity,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             out_parity
);

    logic             valid_d,  valid_q;
    logic [WIDTH-1:0] data_d,   data_q;
    logic [CNT_W-1:0] count_d,  count_q;
    logic             parity_d, parity_q;

    // Next-state selection: load from upstream when enabled, otherwise hold.
    always_comb begin
        valid_d  = valid_q;
        data_d   = data_q;
        count_d  = count_q;
        parity_d = parity_q;
        if (en) begin
            valid_d  = in_valid;
            data_d   = in_data;
            count_d  = in_count;
            parity_d = in_parity;
        end else begin
            valid_d  = valid_q;
            data_d   = data_q;
            count_d  = count_q;
            parity_d = parity_q;
        end
    end

    // Slice registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q  <= 1'b0;
            data_q   <= '0;
            count_q  <= '0;
            parity_q <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            data_q   <= data_d;
            count_q  <= count_d;
            parity_q <= parity_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_data   = data_q;
    assign out_count  = count_q;
    assign out_parity = parity_q;

endmodule

// File: rtl/xor_fold_pipe.sv
// Elastic multi-lane XOR fold: PASS emits one folded word per beat, ACCUM
// emits one running-XOR checksum per packet on its last beat.
module xor_fold_pipe
    import xor_fold_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int LANES  = 2,
    parameter int STAGES = 2,
    parameter int CNT_W  = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   mode,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] in_data,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [CNT_W-1:0]       out_count,
    output logic                   out_parity
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

    function automatic logic parity_of(input logic [WIDTH-1:0] v);
        return ^v;
    endfunction

    logic             en;
    logic             in_fire;
    logic [WIDTH-1:0] fold;

    trk_state_e       state_d, state_q;
    logic             pkt_mode_d, pkt_mode_q;
    logic             cur_mode;
    logic [WIDTH-1:0] acc_d, acc_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic [CNT_W-1:0] cnt_inc;

    logic             inj_valid;
    logic [WIDTH-1:0] inj_data;
    logic [CNT_W-1:0] inj_count;

    logic [STAGES:0]  stg_valid;
    logic [WIDTH-1:0] stg_data  [STAGES+1];
    logic [CNT_W-1:0] stg_count [STAGES+1];
    logic [STAGES:0]  stg_parity;

    assign en       = ~out_valid | out_ready;
    assign in_ready = en & ~reset;
    assign in_fire  = in_valid & in_ready;

    // XOR of all lanes of the incoming beat.
    always_comb begin
        fold = '0;
        for (int k = 0; k < LANES; k++) begin
            fold = fold ^ in_data[k*WIDTH +: WIDTH];
        end
    end

    // Packet tracker, accumulator and saturating beat counter; decides what
    // (if anything) is injected into the pipe this cycle.
    always_comb begin
        state_d    = state_q;
        pkt_mode_d = pkt_mode_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        inj_valid  = 1'b0;
        inj_data   = '0;
        inj_count  = '0;
        cur_mode   = (state_q == ACC) ? pkt_mode_q : mode;
        cnt_inc    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1'b1);
        if (in_fire) begin
            pkt_mode_d = cur_mode;
            if (cur_mode == MODE_PASS) begin
                inj_valid = 1'b1;
                inj_data  = fold;
                inj_count = CNT_ONE;
                state_d   = IDLE;
            end else if (in_last) begin
                inj_valid = 1'b1;
                inj_data  = acc_q ^ fold;
                inj_count = cnt_inc;
                acc_d     = '0;
                cnt_d     = '0;
                state_d   = IDLE;
            end else begin
                acc_d   = acc_q ^ fold;
                cnt_d   = cnt_inc;
                state_d = ACC;
            end
        end else begin
            state_d = state_q;
        end
    end

    // Tracker and accumulator registers; reset drops any partial packet.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            pkt_mode_q <= MODE_PASS;
            acc_q      <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pkt_mode_q <= pkt_mode_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
        end
    end

    assign stg_valid[0]  = inj_valid;
    assign stg_data[0]   = inj_data;
    assign stg_count[0]  = inj_count;
    assign stg_parity[0] = parity_of(inj_data);

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        xor_fold_stage #(
            .WIDTH (WIDTH),
            .CNT_W (CNT_W)
        ) u_stage (
            .clk        (clk),
            .reset      (reset),
            .en         (en),
            .in_valid   (stg_valid[i]),
            .in_data    (stg_data[i]),
            .in_count   (stg_count[i]),
            .in_parity  (stg_parity[i]),
            .out_valid  (stg_valid[i+1]),
            .out_data   (stg_data[i+1]),
            .out_count  (stg_count[i+1]),
            .out_parity (stg_parity[i+1])
        );
    end

    assign out_valid  = stg_valid[STAGES];
    assign out_data   = stg_data[STAGES];
    assign out_count  = stg_count[STAGES];
    assign out_parity = stg_parity[STAGES];

endmodule

// File: tb/tb_xor_fold_pipe.sv
// Directed bench for xor_fold_pipe: a CNT_W=8 instance and a CNT_W=2 instance
// share one stimulus stream; results are checked against a queue of expectations.
module tb_xor_fold_pipe;

    localparam int STAGES = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        mode;
    logic        in_valid;
    logic        in_last;
    logic [15:0] in_data;
    logic        out_ready;

    logic        in_ready,   s_in_ready;
    logic        out_valid,  s_out_valid;
    logic [7:0]  out_data,   s_out_data;
    logic [7:0]  out_count;
    logic [1:0]  s_out_count;
    logic        out_parity, s_out_parity;

    xor_fold_pipe #(.WIDTH(8), .LANES(2), .STAGES(STAGES), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_count(out_count), .out_parity(out_parity)
    );

    xor_fold_pipe #(.WIDTH(8), .LANES(2), .STAGES(STAGES), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .mode(mode), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(s_out_valid), .out_ready(out_ready),
        .out_data(s_out_data), .out_count(s_out_count), .out_parity(s_out_parity)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks  = 0;
    int errors  = 0;
    int results = 0;

    typedef struct {
        logic [7:0] d;
        logic [7:0] c;
        logic [1:0] cs;
        logic       p;
        int         acc;
        bit         lat;
    } exp_t;

    typedef struct {
        logic       m;
        logic       l;
        logic       emit;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] ed;
        int         ec;
        int         ecs;
    } vec_t;

    exp_t q_exp[$];
    exp_t mon_e;
    vec_t vecs[24];
    int   nv;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Output monitor: every accepted result must match the head of the queue.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (q_exp.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got data %0h with no result pending", out_data);
            end else begin
                mon_e = q_exp.pop_front();
                results++;
                check("out_data",     out_data,     mon_e.d);
                check("out_count",    out_count,    mon_e.c);
                check("out_parity",   out_parity,   mon_e.p);
                check("sat_valid",    s_out_valid,  1'b1);
                check("sat_data",     s_out_data,   mon_e.d);
                check("sat_count",    s_out_count,  mon_e.cs);
                check("sat_parity",   s_out_parity, mon_e.p);
                if (mon_e.lat) check("latency", cyc - mon_e.acc, STAGES);
            end
        end
    end

    task automatic send(input logic m, input logic l, input logic [7:0] a, input logic [7:0] b,
                        input logic emit, input logic [7:0] ed, input int ec, input int ecs,
                        input bit lat);
        int n;
        mode     = m;
        in_last  = l;
        in_data  = {b, a};
        in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 200);
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready stayed 0 for beat %0h/%0h", a, b);
        end else if (emit) begin
            q_exp.push_back('{d: ed, c: ec[7:0], cs: ecs[1:0], p: ^ed, acc: cyc, lat: lat});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (q_exp.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", q_exp.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_in_ready"},   in_ready,    1'b0);
        check({tag, "_out_valid"},  out_valid,   1'b0);
        check({tag, "_out_data"},   out_data,    8'h00);
        check({tag, "_out_count"},  out_count,   8'h00);
        check({tag, "_out_parity"}, out_parity,  1'b0);
        check({tag, "_sat_valid"},  s_out_valid, 1'b0);
        check({tag, "_sat_count"},  s_out_count, 2'd0);
    endtask

    initial begin
        reset     = 1'b1;
        mode      = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_data   = 16'h0000;
        out_ready = 1'b1;

        nv = 0;
        // PASS beats (last is ignored in PASS)
        vecs[nv++] = '{1'b0, 1'b0, 1'b1, 8'h0F, 8'hF0, 8'hFF, 1, 1};
        vecs[nv++] = '{1'b0, 1'b0, 1'b1, 8'hAA, 8'hAA, 8'h00, 1, 1};
        vecs[nv++] = '{1'b0, 1'b1, 1'b1, 8'h12, 8'h34, 8'h26, 1, 1};
        vecs[nv++] = '{1'b0, 1'b0, 1'b1, 8'h01, 8'h00, 8'h01, 1, 1};
        // 3-beat ACCUM packet
        vecs[nv++] = '{1'b1, 1'b0, 1'b0, 8'h01, 8'h02, 8'h00, 0, 0};
        vecs[nv++] = '{1'b1, 1'b0, 1'b0, 8'h04, 8'h08, 8'h00, 0, 0};
        vecs[nv++] = '{1'b1, 1'b1, 1'b1, 8'h10, 8'h20, 8'h3F, 3, 3};
        // 6-beat ACCUM packet: count 6 on CNT_W=8, saturates at 3 on CNT_W=2
        for (int i = 0; i < 5; i++) vecs[nv++] = '{1'b1, 1'b0, 1'b0, 8'h01, 8'h00, 8'h00, 0, 0};
        vecs[nv++] = '{1'b1, 1'b1, 1'b1, 8'h01, 8'h00, 8'h00, 6, 3};
        // mode drops to PASS mid-packet; packet stays ACCUM, then a real PASS beat
        vecs[nv++] = '{1'b1, 1'b0, 1'b0, 8'h11, 8'h00, 8'h00, 0, 0};
        vecs[nv++] = '{1'b0, 1'b0, 1'b0, 8'h22, 8'h00, 8'h00, 0, 0};
        vecs[nv++] = '{1'b0, 1'b1, 1'b1, 8'h44, 8'h00, 8'h77, 3, 3};
        vecs[nv++] = '{1'b0, 1'b0, 1'b1, 8'h03, 8'h00, 8'h03, 1, 1};
        // single-beat ACCUM packet
        vecs[nv++] = '{1'b1, 1'b1, 1'b1, 8'h5A, 8'h00, 8'h5A, 1, 1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero_outputs("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < nv; i++) begin
            send(vecs[i].m, vecs[i].l, vecs[i].a, vecs[i].b, vecs[i].emit,
                 vecs[i].ed, vecs[i].ec, vecs[i].ecs, 1'b1);
        end
        wait_drain();

        // Backpressure: output stalled while the sender keeps in_valid high
        fork
            begin
                send(1'b0, 1'b0, 8'hA0, 8'h0B, 1'b1, 8'hAB, 1, 1, 1'b0);
                send(1'b0, 1'b0, 8'h01, 8'h02, 1'b1, 8'h03, 1, 1, 1'b0);
                send(1'b0, 1'b0, 8'h70, 8'h00, 1'b1, 8'h70, 1, 1, 1'b0);
                send(1'b0, 1'b0, 8'hC3, 8'h3C, 1'b1, 8'hFF, 1, 1, 1'b0);
            end
            begin
                out_ready = 1'b0;
                repeat (3) @(posedge clk);
                @(negedge clk);
                check("bp_out_valid", out_valid, 1'b1);
                check("bp_in_ready",  in_ready,  1'b0);
                check("bp_out_data",  out_data,  8'hAB);
                for (int k = 0; k < 2; k++) begin
                    @(negedge clk);
                    check("bp_hold_ready", in_ready,   1'b0);
                    check("bp_hold_data",  out_data,   8'hAB);
                    check("bp_hold_count", out_count,  8'd1);
                    check("bp_hold_par",   out_parity, 1'b1);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        wait_drain();

        // Reset in the middle of an ACCUM packet
        send(1'b1, 1'b0, 8'hFF, 8'h00, 1'b0, 8'h00, 0, 0, 1'b0);
        send(1'b1, 1'b0, 8'hFF, 8'h00, 1'b0, 8'h00, 0, 0, 1'b0);
        reset = 1'b1;
        #1;
        check("rst_in_ready_comb", in_ready, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check_zero_outputs("midrst");
        @(posedge clk);
        #1;
        reset = 1'b0;
        send(1'b1, 1'b1, 8'h05, 8'h00, 1'b1, 8'h05, 1, 1, 1'b1);
        wait_drain();

        check("result_count", results, 14);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
